// File: rtl/delay_tap_arbiter.sv
// Tapped delay line whose single read port is shared by NREQ requesters via a round-robin arbiter.
// Grant is combinational; the id-tagged tap value returns one cycle after the grant.
module delay_tap_arbiter #(
  parameter int BITS  = 16,
  parameter int DELAY = 4,
  parameter int NREQ  = 3,
  localparam int TAPW = (DELAY > 1) ? $clog2(DELAY) : 1,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_din_valid,
  input  logic [BITS-1:0]      i_Din,
  input  logic [NREQ-1:0]      i_req,
  input  logic [NREQ*TAPW-1:0] i_req_tap,
  output logic [NREQ-1:0]      o_gnt,
  output logic                 o_rd_valid,
  output logic [IDW-1:0]       o_rd_id,
  output logic [BITS-1:0]      o_rd_data,
  output logic                 o_tap_err
);

  logic [BITS-1:0] stage_q [DELAY];
  logic [IDW-1:0]  ptr_q, ptr_d;

  logic            hi_found, lo_found, gnt_any;
  logic [IDW-1:0]  hi_id, lo_id, gnt_id;
  logic [TAPW-1:0] gnt_tap;
  logic [BITS-1:0] tap_data;
  logic            tap_bad;

  logic            rd_valid_q, rd_valid_d;
  logic [IDW-1:0]  rd_id_q, rd_id_d;
  logic [BITS-1:0] rd_data_q, rd_data_d;
  logic            tap_err_q, tap_err_d;

  // Lowest request at or above ptr wins; otherwise wrap to the lowest request overall.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_id    = '0;
    lo_id    = '0;
    for (int c = NREQ - 1; c >= 0; c--) begin
      if (i_req[c]) begin
        lo_found = 1'b1;
        lo_id    = IDW'(c);
        if (c >= int'(ptr_q)) begin
          hi_found = 1'b1;
          hi_id    = IDW'(c);
        end
      end
    end
    gnt_id  = hi_found ? hi_id : lo_id;
    gnt_any = lo_found && !i_rst;
    o_gnt   = gnt_any ? (NREQ'(1) << gnt_id) : '0;
  end

  always_comb begin
    gnt_tap = '0;
    for (int c = 0; c < NREQ; c++) begin
      if (gnt_id == IDW'(c)) begin
        gnt_tap = i_req_tap[c*TAPW +: TAPW];
      end
    end
  end

  // Indices that match no stage (only possible when DELAY is not a power of two) flag an error.
  always_comb begin
    tap_data = '0;
    tap_bad  = 1'b1;
    for (int k = 0; k < DELAY; k++) begin
      if (gnt_tap == TAPW'(k)) begin
        tap_data = stage_q[k];
        tap_bad  = 1'b0;
      end
    end
  end

  always_comb begin
    ptr_d      = ptr_q;
    rd_valid_d = gnt_any;
    rd_id_d    = rd_id_q;
    rd_data_d  = rd_data_q;
    tap_err_d  = tap_err_q;
    if (gnt_any) begin
      ptr_d     = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
      rd_id_d   = gnt_id;
      rd_data_d = tap_bad ? '0 : tap_data;
      tap_err_d = tap_bad;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < DELAY; k++) begin
        stage_q[k] <= '0;
      end
      ptr_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_id_q    <= '0;
      rd_data_q  <= '0;
      tap_err_q  <= 1'b0;
    end else begin
      if (i_din_valid) begin
        stage_q[0] <= i_Din;
        for (int k = 1; k < DELAY; k++) begin
          stage_q[k] <= stage_q[k-1];
        end
      end
      ptr_q      <= ptr_d;
      rd_valid_q <= rd_valid_d;
      rd_id_q    <= rd_id_d;
      rd_data_q  <= rd_data_d;
      tap_err_q  <= tap_err_d;
    end
  end

  assign o_rd_valid = rd_valid_q;
  assign o_rd_id    = rd_id_q;
  assign o_rd_data  = rd_data_q;
  assign o_tap_err  = tap_err_q;

endmodule
